// File: rtl/dcache_mem_req_arbiter_pkg.sv
// Shared types and constants for the D-cache memory request arbiter.
// Port indices identify the requesters: load miss, write buffer, AMO.
package dcache_arb_pkg;

  localparam int NUM_PORTS  = 3;
  localparam int TID_W      = 2;
  localparam int NUM_TIDS   = 1 << TID_W;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int PORT_IDX_W = 2;

  typedef logic [TID_W-1:0]      tid_t;
  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t owner;
  } owner_entry_t;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HOLD
  } lock_state_e;

  localparam port_idx_t LOAD_PORT = 2'd0;
  localparam port_idx_t WBUF_PORT = 2'd1;
  localparam port_idx_t AMO_PORT  = 2'd2;
  localparam port_idx_t LAST_PORT = port_idx_t'(NUM_PORTS - 1);

  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == LAST_PORT) ? port_idx_t'(0) : port_idx_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/dcache_mem_req_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// master = the arbiter itself, slave = requesters plus memory/NoC side.
interface dcache_mem_req_arbiter_if;
  import dcache_arb_pkg::*;

  logic [NUM_PORTS-1:0]        req_valid_i;
  logic [NUM_PORTS-1:0]        req_ready_o;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i;
  logic [NUM_PORTS-1:0]        req_we_i;

  logic                        mem_req_valid_o;
  logic                        mem_req_ready_i;
  logic [ADDR_W-1:0]           mem_req_addr_o;
  logic [DATA_W-1:0]           mem_req_wdata_o;
  logic                        mem_req_we_o;
  logic [TID_W-1:0]            mem_req_tid_o;

  logic                        mem_rsp_valid_i;
  logic [TID_W-1:0]            mem_rsp_tid_i;
  logic [DATA_W-1:0]           mem_rsp_rdata_i;

  logic [NUM_PORTS-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]           rsp_rdata_o;
  logic                        busy_o;
  logic                        err_o;
  logic [NUM_PORTS*32-1:0]     stall_cnt_o;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_we_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    output req_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_wdata_o,
    output mem_req_we_o, mem_req_tid_o, rsp_valid_o, rsp_rdata_o,
    output busy_o, err_o, stall_cnt_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_we_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    input  req_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_wdata_o,
    input  mem_req_we_o, mem_req_tid_o, rsp_valid_o, rsp_rdata_o,
    input  busy_o, err_o, stall_cnt_o
  );

endinterface

// File: rtl/dcache_mem_req_arbiter_rr_arb_lock.sv
// Round-robin arbiter with a lock input that freezes the current grant
// while a memory request waits for acceptance.
module rr_arb_lock
  import dcache_arb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 en_i,
  input  logic                 lock_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_idx_t            gnt_idx_o
);

  localparam logic [NUM_PORTS-1:0] GNT_ONE = NUM_PORTS'(1);

  port_idx_t            ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  port_idx_t            gnt_idx_q, gnt_idx_d;
  logic [NUM_PORTS-1:0] rr_gnt;
  port_idx_t            rr_idx;
  port_idx_t            cand;
  logic                 found;

  // Scan requesters starting at the pointer; first asserted one wins.
  always_comb begin
    found  = 1'b0;
    rr_idx = ptr_q;
    cand   = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
      cand = next_port(cand);
    end
    rr_gnt = (found && en_i) ? (GNT_ONE << rr_idx) : '0;
  end

  always_comb begin
    gnt_o     = lock_i ? gnt_q : rr_gnt;
    gnt_idx_o = lock_i ? gnt_idx_q : rr_idx;
    gnt_d     = gnt_o;
    gnt_idx_d = gnt_idx_o;
  end

  always_comb begin
    ptr_d = advance_i ? next_port(gnt_idx_o) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

endmodule

// File: rtl/dcache_mem_req_arbiter.sv
// Shares the D-cache memory request port among requesters, allocates TIDs and
// routes responses by TID. Optional stall counters: define DCACHE_ARB_PERF_EN.
module dcache_mem_req_arbiter
  import dcache_arb_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  dcache_mem_req_arbiter_if.master bus
);

  localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1);

  lock_state_e          state_q, state_d;
  tid_t                 hold_tid_q, hold_tid_d;
  owner_entry_t         owner_q [NUM_TIDS];
  owner_entry_t         owner_d [NUM_TIDS];
  logic                 err_q, err_d;

  logic [NUM_PORTS-1:0] gnt;
  port_idx_t            gnt_idx;
  logic                 lock;
  logic                 tid_avail;
  tid_t                 alloc_tid;
  logic                 handshake;
  owner_entry_t         rsp_entry;
  logic                 rsp_hit;
  logic                 busy;

  // Lowest free TID from registered state, so a TID freed this cycle waits one cycle.
  always_comb begin
    tid_avail = 1'b0;
    alloc_tid = '0;
    for (int t = NUM_TIDS - 1; t >= 0; t--) begin
      if (!owner_q[t].valid) begin
        tid_avail = 1'b1;
        alloc_tid = tid_t'(t);
      end
    end
  end

  assign lock = (state_q == LOCK_HOLD);

  rr_arb_lock u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (bus.req_valid_i),
    .en_i      (tid_avail),
    .lock_i    (lock),
    .advance_i (handshake),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOCK_IDLE;
      hold_tid_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_tid_q <= hold_tid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_tid_d = hold_tid_q;
    case (state_q)
      LOCK_IDLE: begin
        hold_tid_d = alloc_tid;
        if (bus.mem_req_valid_o && !bus.mem_req_ready_i) state_d = LOCK_HOLD;
      end
      LOCK_HOLD: begin
        if (bus.mem_req_ready_i) state_d = LOCK_IDLE;
      end
      default: state_d = LOCK_IDLE;
    endcase
  end

  // Zero-latency mux of the granted port onto the memory request channel.
  always_comb begin
    bus.mem_req_valid_o = |gnt;
    bus.mem_req_tid_o   = lock ? hold_tid_q : alloc_tid;
    bus.mem_req_addr_o  = '0;
    bus.mem_req_wdata_o = '0;
    bus.mem_req_we_o    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        bus.mem_req_addr_o  = bus.req_addr_i[p*ADDR_W +: ADDR_W];
        bus.mem_req_wdata_o = bus.req_wdata_i[p*DATA_W +: DATA_W];
        bus.mem_req_we_o    = bus.req_we_i[p];
      end
    end
    handshake       = bus.mem_req_valid_o & bus.mem_req_ready_i;
    bus.req_ready_o = handshake ? gnt : '0;
  end

  // Allocation and release never collide: the allocated TID is always a free one.
  always_comb begin
    owner_d   = owner_q;
    err_d     = err_q;
    rsp_entry = owner_q[bus.mem_rsp_tid_i];
    rsp_hit   = bus.mem_rsp_valid_i & rsp_entry.valid;
    if (bus.mem_rsp_valid_i && !rsp_entry.valid) err_d = 1'b1;
    if (rsp_hit) owner_d[bus.mem_rsp_tid_i] = '0;
    if (handshake) owner_d[bus.mem_req_tid_o] = '{valid: 1'b1, owner: gnt_idx};
    bus.rsp_valid_o = rsp_hit ? (PORT_ONE << rsp_entry.owner) : '0;
    bus.rsp_rdata_o = bus.mem_rsp_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < NUM_TIDS; t++) owner_q[t] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_TIDS; t++) owner_q[t] <= owner_d[t];
      err_q <= err_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int t = 0; t < NUM_TIDS; t++) busy = busy | owner_q[t].valid;
    bus.busy_o = busy;
    bus.err_o  = err_q;
  end

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] stall_cnt_q [NUM_PORTS];
  logic [31:0] stall_cnt_d [NUM_PORTS];

  // Saturating per-port count of cycles a request waited without acceptance.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      stall_cnt_d[p] = stall_cnt_q[p];
      if (bus.req_valid_i[p] && !bus.req_ready_o[p] && (stall_cnt_q[p] != 32'hFFFF_FFFF))
        stall_cnt_d[p] = stall_cnt_q[p] + 32'd1;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) bus.stall_cnt_o[p*32 +: 32] = stall_cnt_q[p];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_PORTS; p++) stall_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) stall_cnt_q[p] <= stall_cnt_d[p];
    end
  end
`else
  assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: doc/dcache_mem_req_arbiter.md
Name: dcache_mem_req_arbiter

Overview:
- Shares the single write-through D-cache memory request port between NUM_PORTS requesters: load-miss unit, write buffer and AMO unit.
- Allocates a transaction ID (TID) per issued request and tracks outstanding TIDs.
- Routes each returning response to its owning requester by TID.
- Sits between the WT D-cache miss/write-buffer logic and the NoC adapter.

Parameters:
- NUM_PORTS, 3, number of requesters (index 0 = load miss, 1 = write buffer, 2 = AMO).
- TID_W, 2, memory transaction ID width (MemTidWidth); NUM_TIDS = 2**TID_W.
- ADDR_W, 64, request address width.
- DATA_W, 64, request/response data width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_PORTS  per-port request valid
- req_ready_o  out  NUM_PORTS  per-port request accepted
- req_addr_i  in  NUM_PORTS*ADDR_W  per-port address
- req_wdata_i  in  NUM_PORTS*DATA_W  per-port write data
- req_we_i  in  NUM_PORTS  per-port write enable
- mem_req_valid_o  out  1  request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_W  granted address
- mem_req_wdata_o  out  DATA_W  granted write data
- mem_req_we_o  out  1  granted write enable
- mem_req_tid_o  out  TID_W  allocated TID
- mem_rsp_valid_i  in  1  response valid (always accepted)
- mem_rsp_tid_i  in  TID_W  response TID
- mem_rsp_rdata_i  in  DATA_W  response data
- rsp_valid_o  out  NUM_PORTS  one-hot response strobe to owner
- rsp_rdata_o  out  DATA_W  response data, broadcast to all ports
- busy_o  out  1  any TID outstanding
- err_o  out  1  sticky: response to a non-allocated TID
- stall_cnt_o  out  NUM_PORTS*32  per-port stall counters (optional feature)

Behaviour:
- Reset (async, rst_ni low):
  - All TIDs free; owner table cleared; round-robin pointer = 0; lock cleared; err_o = 0.
  - All outputs 0.
- Arbitration:
  - Round-robin over asserted req_valid_i, starting at the pointer.
  - Arbitration happens only when no lock is held and at least one TID is free.
  - mem_req_* is a combinational mux of the granted port; zero-cycle latency to memory.
- Lock (two states: IDLE, HOLD):
  - IDLE→HOLD when mem_req_valid_o=1 and mem_req_ready_i=0.
  - In HOLD, grant and mem_req_tid_o are frozen; valid/addr/data/we must stay stable.
  - HOLD→IDLE on handshake.
  - Requesters keep req_valid_i asserted until req_ready_o.
- Handshake: req_ready_o[g] = mem_req_valid_o & mem_req_ready_i for granted port g only.
  - On handshake, pointer ← g+1 mod NUM_PORTS.
  - The TID is marked allocated and owner[tid] ← g, effective next cycle.
- TID allocation:
  - Lowest-index free TID, computed from the registered free vector.
  - A TID freed in cycle N is reusable from cycle N+1, never the same cycle.
- TIDs exhausted: mem_req_valid_o = 0 and all req_ready_o = 0 until a response frees one.
  - No lock is entered in this case.
- Response handling:
  - rsp_valid_o[owner[mem_rsp_tid_i]] = 1 in the same cycle (combinational); rsp_rdata_o = mem_rsp_rdata_i.
  - The TID is freed at the clock edge.
  - Response to a free TID: no rsp_valid_o, table unchanged, err_o set until reset.
- Simultaneous allocation and response in one cycle: both take effect; they can never target the same TID.
- busy_o = OR of the allocated vector (registered state).

Optional Feature:
- DCACHE_ARB_PERF_EN defined:
  - Per-port 32-bit saturating counter increments each cycle req_valid_i[p]=1 and req_ready_o[p]=0.
  - Counters cleared on reset and hold at 0xFFFF_FFFF.
- Undefined: no counter registers; stall_cnt_o tied to 0.

Decomposition:
- Package dcache_arb_pkg:
  - tid_t, port_idx_t;
  - owner-table entry struct {valid, port_idx_t owner};
  - NUM_TIDS constant;
  - port index constants LOAD_PORT=0, WBUF_PORT=1, AMO_PORT=2.
- One sub-module rr_arb_lock: round-robin arbiter with lock input and one-hot grant output.
- TID table and response routing stay in the top module.

Test Plan:
- Ports 0,1,2 request together, mem_req_ready_i=1:
  - Grants in order 0,1,2 on consecutive cycles with TIDs 0,1,2.
  - Pointer ends at 0.
- Port 1 requests, mem_req_ready_i=0 for 3 cycles, port 0 raises req mid-stall:
  - Grant stays on port 1 with TID 0 and stable addr.
  - Handshake on cycle 4; port 0 issues next.
- Issue 4 requests, no responses:
  - 5th request gets mem_req_valid_o=0 while busy_o=1.
  - Response for TID 2 → next request gets TID 2 the following cycle.
- Response TID 1 owned by port 2, rdata=0xDEAD_BEEF:
  - rsp_valid_o=3'b100 same cycle, rsp_rdata_o=0xDEAD_BEEF.
- Response TID 3 while TID 3 is free:
  - rsp_valid_o=0, err_o=1 and remains 1 until reset.
- Assert rst_ni low with 2 TIDs outstanding and a lock held:
  - Next cycle busy_o=0, mem_req_valid_o=0; first new request gets TID 0 from port 0.
  - With DCACHE_ARB_PERF_EN, counters read 0.
